itch_stream_parser: RTL

ITCH_STREAM_PARSER -- requirements
Module: itch_stream_parser

---
 rtl/itch_stream_parser.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/itch_stream_parser.sv
// ITCH 5.0 stream parser: walks [len_hi, len_lo, body] blocks of a stripped packet payload
// and reports Add/Delete/Executed/Cancel/Replace messages with their decoded fields.
module itch_stream_parser #(
    parameter int PRICE_W    = 32,
    parameter int SHARES_W   = 32,
    parameter int EN_CANCEL  = 1,
    parameter int EN_REPLACE = 1
) (
    input  logic                clkIn,
    input  logic                rstNIn,
    input  logic [7:0]          dataIn,
    input  logic                dataValidIn,
    input  logic                packetLostIn,
    output logic                msgValidOut,
    output logic [2:0]          msgTypeOut,
    output logic [15:0]         locateOut,
    output logic [63:0]         refNumOut,
    output logic [63:0]         newRefNumOut,
    output logic [SHARES_W-1:0] sharesOut,
    output logic [PRICE_W-1:0]  priceOut,
    output logic                buySellOut,
    output logic                errorOut
);

    localparam logic [2:0] T_NONE    = 3'd0;
    localparam logic [2:0] T_ADD     = 3'd1;
    localparam logic [2:0] T_DELETE  = 3'd2;
    localparam logic [2:0] T_EXEC    = 3'd3;
    localparam logic [2:0] T_CANCEL  = 3'd4;
    localparam logic [2:0] T_REPLACE = 3'd5;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        BODY   = 3'd2,
        SKIP   = 3'd3,
        DROP   = 3'd4
    } state_t;

    // Types switched off by parameter decode as unknown so they are skipped silently.
    function automatic logic [2:0] decode_type(input logic [7:0] type_byte);
        case (type_byte)
            8'h41:   decode_type = T_ADD;
            8'h44:   decode_type = T_DELETE;
            8'h45:   decode_type = T_EXEC;
            8'h58:   decode_type = (EN_CANCEL != 0) ? T_CANCEL : T_NONE;
            8'h55:   decode_type = (EN_REPLACE != 0) ? T_REPLACE : T_NONE;
            default: decode_type = T_NONE;
        endcase
    endfunction

    function automatic logic [15:0] expected_len(input logic [2:0] msg_type);
        case (msg_type)
            T_ADD:     expected_len = 16'd36;
            T_DELETE:  expected_len = 16'd19;
            T_EXEC:    expected_len = 16'd31;
            T_CANCEL:  expected_len = 16'd23;
            T_REPLACE: expected_len = 16'd35;
            default:   expected_len = 16'd0;
        endcase
    endfunction

    state_t        state_r;
    logic [15:0]   len_r;
    logic [15:0]   cnt_r;
    logic          err_pend_r;

    logic [2:0]    sh_type_r;
    logic [15:0]   sh_loc_r;
    logic [63:0]   sh_ref_r;
    logic [63:0]   sh_newref_r;
    logic [31:0]   sh_shares_r;
    logic [31:0]   sh_price_r;
    logic          sh_side_r;

    logic [2:0]    sh_type_s;
    logic [15:0]   sh_loc_s;
    logic [63:0]   sh_ref_s;
    logic [63:0]   sh_newref_s;
    logic [31:0]   sh_shares_s;
    logic [31:0]   sh_price_s;
    logic          sh_side_s;
    logic          last_s;

    logic                msg_valid_r;
    logic [2:0]          msg_type_r;
    logic [15:0]         locate_r;
    logic [63:0]         ref_num_r;
    logic [63:0]         new_ref_num_r;
    logic [SHARES_W-1:0] shares_r;
    logic [PRICE_W-1:0]  price_r;
    logic                buy_sell_r;
    logic                error_r;

    assign last_s = (cnt_r == (len_r - 16'd1));

    // Field shadow next-state: shift the current body byte into whichever field owns its offset.
    always_comb begin
        sh_type_s   = sh_type_r;
        sh_loc_s    = sh_loc_r;
        sh_ref_s    = sh_ref_r;
        sh_newref_s = sh_newref_r;
        sh_shares_s = sh_shares_r;
        sh_price_s  = sh_price_r;
        sh_side_s   = sh_side_r;
        case (cnt_r) inside
            16'd0: begin
                // Clearing at the type byte is what makes unused fields read zero.
                sh_type_s   = decode_type(dataIn);
                sh_loc_s    = 16'd0;
                sh_ref_s    = 64'd0;
                sh_newref_s = 64'd0;
                sh_shares_s = 32'd0;
                sh_price_s  = 32'd0;
                sh_side_s   = 1'b0;
            end
            [16'd1:16'd2]:   sh_loc_s = {sh_loc_r[7:0], dataIn};
            [16'd11:16'd18]: sh_ref_s = {sh_ref_r[55:0], dataIn};
            default: begin
                case (sh_type_r)
                    T_ADD: begin
                        case (cnt_r) inside
                            16'd19:          sh_side_s   = (dataIn == 8'h42);
                            [16'd20:16'd23]: sh_shares_s = {sh_shares_r[23:0], dataIn};
                            [16'd32:16'd35]: sh_price_s  = {sh_price_r[23:0], dataIn};
                            default:         sh_side_s   = sh_side_r;
                        endcase
                    end
                    T_EXEC, T_CANCEL: begin
                        case (cnt_r) inside
                            [16'd19:16'd22]: sh_shares_s = {sh_shares_r[23:0], dataIn};
                            default:         sh_shares_s = sh_shares_r;
                        endcase
                    end
                    T_REPLACE: begin
                        case (cnt_r) inside
                            [16'd19:16'd26]: sh_newref_s = {sh_newref_r[55:0], dataIn};
                            [16'd27:16'd30]: sh_shares_s = {sh_shares_r[23:0], dataIn};
                            [16'd31:16'd34]: sh_price_s  = {sh_price_r[23:0], dataIn};
                            default:         sh_newref_s = sh_newref_r;
                        endcase
                    end
                    default: sh_type_s = sh_type_r;
                endcase
            end
        endcase
    end

    // Block framing FSM, field shadows and registered output strobes.
    always_ff @(posedge clkIn or negedge rstNIn) begin
        if (!rstNIn) begin
            state_r       <= LEN_HI;
            len_r         <= 16'd0;
            cnt_r         <= 16'd0;
            err_pend_r    <= 1'b0;
            sh_type_r     <= T_NONE;
            sh_loc_r      <= 16'd0;
            sh_ref_r      <= 64'd0;
            sh_newref_r   <= 64'd0;
            sh_shares_r   <= 32'd0;
            sh_price_r    <= 32'd0;
            sh_side_r     <= 1'b0;
            msg_valid_r   <= 1'b0;
            msg_type_r    <= 3'd0;
            locate_r      <= 16'd0;
            ref_num_r     <= 64'd0;
            new_ref_num_r <= 64'd0;
            shares_r      <= '0;
            price_r       <= '0;
            buy_sell_r    <= 1'b0;
            error_r       <= 1'b0;
        end else begin
            msg_valid_r <= 1'b0;
            error_r     <= 1'b0;
            if (packetLostIn) begin
                state_r <= DROP;
            end else begin
                case (state_r)
                    LEN_HI: begin
                        if (dataValidIn) begin
                            len_r[15:8] <= dataIn;
                            state_r     <= LEN_LO;
                        end
                    end
                    LEN_LO: begin
                        if (dataValidIn) begin
                            len_r[7:0] <= dataIn;
                            cnt_r      <= 16'd0;
                            state_r    <= ({len_r[15:8], dataIn} == 16'd0) ? LEN_HI : BODY;
                        end else begin
                            error_r <= 1'b1;
                            state_r <= LEN_HI;
                        end
                    end
                    BODY: begin
                        if (dataValidIn) begin
                            cnt_r       <= cnt_r + 16'd1;
                            sh_type_r   <= sh_type_s;
                            sh_loc_r    <= sh_loc_s;
                            sh_ref_r    <= sh_ref_s;
                            sh_newref_r <= sh_newref_s;
                            sh_shares_r <= sh_shares_s;
                            sh_price_r  <= sh_price_s;
                            sh_side_r   <= sh_side_s;
                            if (cnt_r == 16'd0) begin
                                if (sh_type_s == T_NONE) begin
                                    err_pend_r <= 1'b0;
                                    state_r    <= last_s ? LEN_HI : SKIP;
                                end else if (len_r != expected_len(sh_type_s)) begin
                                    // All expected lengths exceed one, so a mismatch may end right here.
                                    if (last_s) begin
                                        error_r <= 1'b1;
                                        state_r <= LEN_HI;
                                    end else begin
                                        err_pend_r <= 1'b1;
                                        state_r    <= SKIP;
                                    end
                                end
                            end else if (last_s) begin
                                msg_valid_r   <= 1'b1;
                                msg_type_r    <= sh_type_r;
                                locate_r      <= sh_loc_s;
                                ref_num_r     <= sh_ref_s;
                                new_ref_num_r <= sh_newref_s;
                                shares_r      <= sh_shares_s[SHARES_W-1:0];
                                price_r       <= sh_price_s[PRICE_W-1:0];
                                buy_sell_r    <= sh_side_s;
                                state_r       <= LEN_HI;
                            end
                        end else begin
                            error_r <= 1'b1;
                            state_r <= LEN_HI;
                        end
                    end
                    SKIP: begin
                        if (dataValidIn) begin
                            cnt_r <= cnt_r + 16'd1;
                            if (last_s) begin
                                error_r <= err_pend_r;
                                state_r <= LEN_HI;
                            end
                        end else begin
                            error_r <= 1'b1;
                            state_r <= LEN_HI;
                        end
                    end
                    DROP: begin
                        if (!dataValidIn) begin
                            state_r <= LEN_HI;
                        end
                    end
                    default: state_r <= LEN_HI;
                endcase
            end
        end
    end

    assign msgValidOut  = msg_valid_r;
    assign msgTypeOut   = msg_type_r;
    assign locateOut    = locate_r;
    assign refNumOut    = ref_num_r;
    assign newRefNumOut = new_ref_num_r;
    assign sharesOut    = shares_r;
    assign priceOut     = price_r;
    assign buySellOut   = buy_sell_r;
    assign errorOut     = error_r;

endmodule
